// File: rtl/pitch_lookup_arbiter.sv
// Round-robin arbiter that shares one pitch lookup unit among several voices.
// Each granted voice gets one enable/valid handshake with the lookup. The
// result returns with a one-cycle done pulse. A watchdog aborts a lookup that
// never answers; in that case it returns a zero phase delta and flags an error.
module pitch_lookup_arbiter #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_VOICES-1:0]   i_req,
    input  logic [6*NUM_VOICES-1:0] i_pitch,
    output logic [NUM_VOICES-1:0]   o_done,
    output logic                    o_error,
    output logic [31:0]             o_phase_delta,
    output logic                    o_lookup_enable,
    output logic [5:0]              o_lookup_pitch,
    input  logic                    i_lookup_valid,
    input  logic [31:0]             i_lookup_phase_delta
);

    localparam int unsigned IdxW = $clog2(NUM_VOICES);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    localparam logic [IdxW-1:0] LastInit = IdxW'(NUM_VOICES - 1);
    localparam logic [CntW-1:0] CntMax   = CntW'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDeliver
    } state_e;

    state_e          state_q;
    logic [IdxW-1:0] last_q;
    logic [IdxW-1:0] grant_q;
    logic [CntW-1:0] wd_cnt_q;
    logic            wd_expired_q;

    logic [IdxW-1:0]       rr_idx;
    logic                  rr_found;
    logic [5:0]            rr_pitch;
    logic [NUM_VOICES-1:0] grant_oh;

    // Round-robin search: first requester at or above last+1, wrapping to 0.
    always_comb begin
        int unsigned cand;
        rr_idx   = '0;
        rr_found = 1'b0;
        cand     = 0;
        for (int unsigned i = 1; i <= NUM_VOICES; i++) begin
            cand = 32'(last_q) + i;
            if (cand >= NUM_VOICES) begin
                cand = cand - NUM_VOICES;
            end
            if (!rr_found && i_req[IdxW'(cand)]) begin
                rr_found = 1'b1;
                rr_idx   = IdxW'(cand);
            end
        end
    end

    // Pitch of the voice the search would grant this cycle.
    always_comb begin
        rr_pitch = '0;
        for (int unsigned k = 0; k < NUM_VOICES; k++) begin
            if (rr_idx == IdxW'(k)) begin
                rr_pitch = i_pitch[6*k +: 6];
            end
        end
    end

    // One-hot form of the current grant, used for the done pulse.
    always_comb begin
        grant_oh = '0;
        for (int unsigned k = 0; k < NUM_VOICES; k++) begin
            grant_oh[k] = (grant_q == IdxW'(k));
        end
    end

    // Service FSM with registered outputs and saturating watchdog.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q         <= StIdle;
            last_q          <= LastInit;
            grant_q         <= '0;
            wd_cnt_q        <= '0;
            wd_expired_q    <= 1'b0;
            o_done          <= '0;
            o_error         <= 1'b0;
            o_phase_delta   <= '0;
            o_lookup_enable <= 1'b0;
            o_lookup_pitch  <= '0;
        end else begin
            o_done          <= '0;
            o_error         <= 1'b0;
            o_lookup_enable <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rr_found) begin
                        grant_q         <= rr_idx;
                        o_lookup_pitch  <= rr_pitch;
                        o_lookup_enable <= 1'b1;
                        state_q         <= StIssue;
                    end
                end
                StIssue: begin
                    wd_cnt_q     <= '0;
                    wd_expired_q <= 1'b0;
                    state_q      <= StWait;
                end
                StWait: begin
                    if (i_lookup_valid) begin
                        o_phase_delta <= i_lookup_phase_delta;
                        o_done        <= grant_oh;
                        o_error       <= 1'b0;
                        state_q       <= StDeliver;
                    end else if (wd_expired_q) begin
                        // Abort comes one WAIT cycle after the counter saturates.
                        o_phase_delta <= '0;
                        o_done        <= grant_oh;
                        o_error       <= 1'b1;
                        state_q       <= StDeliver;
                    end else if (wd_cnt_q == CntMax) begin
                        wd_expired_q <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end
                StDeliver: begin
                    last_q  <= grant_q;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pitch_lookup_arbiter.sv
// Bench for pitch_lookup_arbiter. A latency-4 lookup model answers
// 32'h1000_0000 + pitch. Expected services go into a scoreboard and are
// matched against each o_done pulse.
module tb_pitch_lookup_arbiter;

    localparam int NV = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NV-1:0] req;
    logic [6*NV-1:0] pitch;
    logic [NV-1:0] done;
    logic          err;
    logic [31:0]   pd;
    logic          en;
    logic [5:0]    lpitch;
    logic          lvalid;
    logic [31:0]   ldata;

    int          cyc = 0;
    int          lk_due = -1;
    logic [31:0] lk_data = 32'h0;
    bit          mute = 1'b0;
    bit          stray_v = 1'b0;
    logic [31:0] stray_d = 32'hDEAD_BEEF;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [NV-1:0] done;
        logic [31:0]   pd;
        logic          err;
        int            cyc;
    } sb_t;

    sb_t sb[$];

    typedef struct {
        int            voice;
        logic [5:0]    pitch;
        bit            mute;
        bit            drop;
        logic [NV-1:0] exp_done;
        logic [31:0]   exp_pd;
        logic          exp_err;
        int            lat;
    } vec_t;

    vec_t vecs[4];

    pitch_lookup_arbiter #(
        .NUM_VOICES(NV),
        .TIMEOUT   (TO)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_req               (req),
        .i_pitch             (pitch),
        .o_done              (done),
        .o_error             (err),
        .o_phase_delta       (pd),
        .o_lookup_enable     (en),
        .o_lookup_pitch      (lpitch),
        .i_lookup_valid      (lvalid),
        .i_lookup_phase_delta(ldata)
    );

    always #5 clk = ~clk;

    // Cycle counter and lookup model: valid 4 cycles after enable.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (en === 1'b1 && !mute) begin
            lk_due  <= cyc + 4;
            lk_data <= 32'h1000_0000 + {26'd0, lpitch};
        end
    end

    assign lvalid = stray_v | (cyc == lk_due);
    assign ldata  = stray_v ? stray_d : lk_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_done(input int v, input logic [31:0] pdv, input logic e, input int c);
        sb_t ent;
        ent.done = '0;
        ent.done[v] = 1'b1;
        ent.pd  = pdv;
        ent.err = e;
        ent.cyc = c;
        sb.push_back(ent);
    endtask

    // Advance to the next negedge; match any done pulse against the scoreboard.
    task automatic tick();
        sb_t ent;
        @(negedge clk);
        if ((|done) === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=%b required=0000 (cycle %0d)", done, cyc);
            end else begin
                ent = sb.pop_front();
                check("done_vector", 32'(done), 32'(ent.done));
                check("done_cycle", cyc, ent.cyc);
                check("done_phase_delta", pd, ent.pd);
                check("done_error", 32'(err), 32'(ent.err));
            end
            req = req & ~done;
        end
    endtask

    task automatic wait_sb(input int limit, input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s outstanding=%0d required=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_error"}, 32'(err), 32'h0);
        check({tag, "_phase_delta"}, pd, 32'h0);
        check({tag, "_enable"}, 32'(en), 32'h0);
        check({tag, "_lookup_pitch"}, 32'(lpitch), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        vec_t v;
        int   t;

        vecs[0] = '{voice: 2, pitch: 6'd5,  mute: 1'b0, drop: 1'b0, exp_done: 4'b0100,
                    exp_pd: 32'h1000_0005, exp_err: 1'b0, lat: 6};
        vecs[1] = '{voice: 1, pitch: 6'd9,  mute: 1'b1, drop: 1'b0, exp_done: 4'b0010,
                    exp_pd: 32'h0000_0000, exp_err: 1'b1, lat: TO + 4};
        vecs[2] = '{voice: 3, pitch: 6'h3F, mute: 1'b0, drop: 1'b1, exp_done: 4'b1000,
                    exp_pd: 32'h1000_003F, exp_err: 1'b0, lat: 6};
        vecs[3] = '{voice: 0, pitch: 6'h2A, mute: 1'b0, drop: 1'b0, exp_done: 4'b0001,
                    exp_pd: 32'h1000_002A, exp_err: 1'b0, lat: 6};

        rst_n = 1'b0;
        req   = '0;
        pitch = '0;
        tick();
        check_zero("reset");
        tick();
        rst_n = 1'b1;
        while (cyc < 10) tick();

        // Single-voice services: normal, timeout, dropped request, voice 0.
        for (int k = 0; k < 4; k++) begin
            v = vecs[k];
            if (k != 0) begin
                tick();
                tick();
            end
            t = cyc;
            mute = v.mute;
            pitch[v.voice*6 +: 6] = v.pitch;
            req[v.voice] = 1'b1;
            begin
                sb_t ent;
                ent.done = v.exp_done;
                ent.pd   = v.exp_pd;
                ent.err  = v.exp_err;
                ent.cyc  = t + v.lat;
                sb.push_back(ent);
            end
            tick();
            check("issue_enable", 32'(en), 32'h1);
            check("issue_pitch", 32'(lpitch), 32'(v.pitch));
            tick();
            if (v.drop) req[v.voice] = 1'b0;
            wait_sb(40, "vector_done");
            mute = 1'b0;
            // Late or stray valid in IDLE must not touch the held result.
            tick();
            stray_v = 1'b1;
            tick();
            stray_v = 1'b0;
            tick();
            check("stray_hold_phase_delta", pd, v.exp_pd);
            check("stray_no_done", 32'(done), 32'h0);
        end

        // All four request at reset exit: order 0,1,2,3, 7 cycles apart.
        tick();
        rst_n = 1'b0;
        req   = 4'hF;
        pitch = {6'h13, 6'h12, 6'h11, 6'h10};
        tick();
        check_zero("reset_rr");
        rst_n = 1'b1;
        t = cyc;
        for (int k = 0; k < 4; k++) begin
            expect_done(k, 32'h1000_0010 + 32'(k), 1'b0, t + 6 + 7*k);
        end
        wait_sb(80, "rr_all");

        // Voices 1 and 3 re-request after voice 3 was last: 1 then 3.
        tick();
        t = cyc;
        req = 4'b1010;
        expect_done(1, 32'h1000_0011, 1'b0, t + 6);
        expect_done(3, 32'h1000_0013, 1'b0, t + 13);
        wait_sb(40, "rr_pair");

        // Reset during WAIT: no done for voice 2; then voice 0 wins over 3.
        tick();
        t = cyc;
        pitch[12 +: 6] = 6'h22;
        req = 4'b0100;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check_zero("reset_wait");
        rst_n = 1'b1;
        req = 4'b1001;
        pitch[0 +: 6]  = 6'h01;
        pitch[18 +: 6] = 6'h03;
        t = cyc;
        expect_done(0, 32'h1000_0001, 1'b0, t + 6);
        expect_done(3, 32'h1000_0003, 1'b0, t + 13);
        wait_sb(40, "reset_then_rr");

        // Stray DEAD_BEEF in IDLE leaves the result alone.
        tick();
        stray_v = 1'b1;
        tick();
        stray_v = 1'b0;
        tick();
        tick();
        check("idle_stray_phase_delta", pd, 32'h1000_0003);
        check("idle_stray_error", 32'(err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
